// File: rtl/axi4_stream_pkg.sv
// Shared types and sizing helpers for the AXI4-Stream multiply responder.
package axi4_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RX,
        CALC,
        TX
    } state_e;

    // Beats needed to carry one operand of sz bits on a dsz-bit stream.
    function automatic int unsigned op_beats(input int unsigned sz, input int unsigned dsz);
        return sz / dsz;
    endfunction

    // Beats needed to carry the double-width product.
    function automatic int unsigned res_beats(input int unsigned sz, input int unsigned dsz);
        return 2 * op_beats(sz, dsz);
    endfunction

endpackage

// File: rtl/axi4_stream_serializer.sv
// Product shift register: loads a Width-bit word and streams it out LSB beat first.
module axi4_stream_serializer
    import axi4_stream_pkg::*;
#(
    parameter int unsigned Width = 64,
    parameter int unsigned Dsz   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] data_i,
    output logic [Dsz-1:0]   tdata_o,
    output logic             tvalid_o,
    input  logic             tready_i,
    output logic             tlast_o,
    output logic             done_o
);

    localparam int unsigned Beats = op_beats(Width, Dsz);
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;

    logic [Width-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             last_beat;
    logic             fire;

    assign last_beat = (cnt_q == CntW'(Beats - 1));
    assign fire      = valid_q & tready_i;

    // Next-state: load a fresh word, or advance one beat on each accepted transfer.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (fire) begin
            if (last_beat) begin
                cnt_d   = '0;
                valid_d = 1'b0;
            end else begin
                shift_d = shift_q >> Dsz;
                cnt_d   = cnt_q + CntW'(1);
            end
        end
    end

    // State registers; outputs are driven straight from these so they hold under back-pressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign tdata_o  = shift_q[Dsz-1:0];
    assign tvalid_o = valid_q;
    assign tlast_o  = valid_q & last_beat;
    assign done_o   = fire & last_beat;

endmodule

// File: rtl/axi4_stream_mul_responder.sv
// Responder end of the AXI4-Stream multiply link: collects a/b, multiplies, streams the product.
module axi4_stream_mul_responder
    import axi4_stream_pkg::*;
#(
    parameter int unsigned SZ  = 32,
    parameter int unsigned DSZ = 8
) (
    input  logic           clk,
    input  logic           _rst,
    input  logic [DSZ-1:0] tdata_to_slave,
    input  logic           tvalid_to_slave,
    output logic           tready_to_slave,
    input  logic           tlast_to_slave,
    output logic [DSZ-1:0] tdata_to_master,
    output logic           tvalid_to_master,
    input  logic           tready_to_master,
    output logic           tlast_to_master,
    output logic           frame_err
);

    localparam int unsigned InBeats = 2 * op_beats(SZ, DSZ);
    localparam int unsigned CntW    = $clog2(InBeats);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2*SZ-1:0]   op_q, op_d;     // {b, a}
    logic [2*SZ-1:0]   prod_q, prod_d;
    logic              load_q, load_d;
    logic              frame_err_q, frame_err_d;
    logic              accept;
    logic              ser_done;

    assign tready_to_slave = (state_q == RX);
    assign accept          = tready_to_slave & tvalid_to_slave;

    // FSM next-state, operand capture and framing checks.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        prod_d      = prod_q;
        frame_err_d = 1'b0;
        load_d      = 1'b0;
        unique case (state_q)
            IDLE: state_d = RX;
            RX: begin
                if (accept) begin
                    op_d[cnt_q*DSZ +: DSZ] = tdata_to_slave;
                    if (cnt_q == CntW'(InBeats - 1)) begin
                        // Full frame: tlast is not required on the final beat.
                        cnt_d   = '0;
                        state_d = CALC;
                    end else if (tlast_to_slave) begin
                        // Early tlast aborts the frame and discards everything so far.
                        cnt_d       = '0;
                        op_d        = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            CALC: begin
                prod_d  = {{SZ{1'b0}}, op_q[SZ-1:0]} * {{SZ{1'b0}}, op_q[2*SZ-1:SZ]};
                load_d  = 1'b1;
                state_d = TX;
            end
            TX: begin
                if (ser_done) state_d = RX;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand and product registers.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            prod_q      <= '0;
            load_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            prod_q      <= prod_d;
            load_q      <= load_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;

    axi4_stream_serializer #(
        .Width (2 * SZ),
        .Dsz   (DSZ)
    ) u_serializer (
        .clk_i    (clk),
        .rst_ni   (_rst),
        .load_i   (load_q),
        .data_i   (prod_q),
        .tdata_o  (tdata_to_master),
        .tvalid_o (tvalid_to_master),
        .tready_i (tready_to_master),
        .tlast_o  (tlast_to_master),
        .done_o   (ser_done)
    );

endmodule

// File: tb/tb_axi4_stream_mul_responder.sv
// Directed bench for axi4_stream_mul_responder (SZ=32, DSZ=8).
module tb_axi4_stream_mul_responder;

    logic       clk;
    logic       _rst;
    logic [7:0] tdata_to_slave;
    logic       tvalid_to_slave;
    logic       tready_to_slave;
    logic       tlast_to_slave;
    logic [7:0] tdata_to_master;
    logic       tvalid_to_master;
    logic       tready_to_master;
    logic       tlast_to_master;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
    } vec_t;

    axi4_stream_mul_responder #(
        .SZ  (32),
        .DSZ (8)
    ) dut (
        .clk              (clk),
        ._rst             (_rst),
        .tdata_to_slave   (tdata_to_slave),
        .tvalid_to_slave  (tvalid_to_slave),
        .tready_to_slave  (tready_to_slave),
        .tlast_to_slave   (tlast_to_slave),
        .tdata_to_master  (tdata_to_master),
        .tvalid_to_master (tvalid_to_master),
        .tready_to_master (tready_to_master),
        .tlast_to_master  (tlast_to_master),
        .frame_err        (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat is taken.
    task automatic send_beat(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        tdata_to_slave  = d;
        tvalid_to_slave = 1'b1;
        tlast_to_slave  = last;
        while (!tready_to_slave && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", {63'd0, tready_to_slave}, 64'd1);
        @(negedge clk);
        tvalid_to_slave = 1'b0;
        tlast_to_slave  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b,
                              input int last_idx, input int nbeats);
        logic [63:0] ops;
        ops = {b, a};
        for (int k = 0; k < nbeats; k++) send_beat(ops[k*8 +: 8], k == last_idx);
    endtask

    // Collects nbeats result beats; optionally stalls on one beat and checks it holds.
    task automatic recv_frame(input int nbeats, input int stall_beat, input int stall_cycles,
                              input logic [63:0] exp_prod,
                              output logic [63:0] p, output logic [7:0] lasts);
        logic [7:0] exp_beat;
        p     = '0;
        lasts = '0;
        for (int i = 0; i < nbeats; i++) begin
            int n;
            n = 0;
            tready_to_master = 1'b1;
            while (!tvalid_to_master && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("recv_valid", {63'd0, tvalid_to_master}, 64'd1);
            if (i == stall_beat) begin
                exp_beat = exp_prod[i*8 +: 8];
                tready_to_master = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    check("stall_hold", {54'd0, tvalid_to_master, tlast_to_master, tdata_to_master},
                          {54'd0, 1'b1, 1'b0, exp_beat});
                end
                tready_to_master = 1'b1;
            end
            p[i*8 +: 8] = tdata_to_master;
            lasts[i]    = tlast_to_master;
            @(negedge clk);
        end
    endtask

    vec_t        vecs[6];
    logic [63:0] prod;
    logic [7:0]  lasts;
    logic        seen;

    initial begin
        vecs[0] = '{32'd2,         32'd3,         64'h6};
        vecs[1] = '{32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000};
        vecs[2] = '{32'h8000_0000, 32'd2,         64'h1_0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'd1,         64'hFFFF_FFFF};
        vecs[4] = '{32'h100,       32'hFF,        64'hFF00};
        vecs[5] = '{32'd0,         32'hDEAD_BEEF, 64'h0};

        _rst             = 1'b0;
        tdata_to_slave   = '0;
        tvalid_to_slave  = 1'b0;
        tlast_to_slave   = 1'b0;
        tready_to_master = 1'b1;

        // Reset values and first ready.
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {52'd0, tready_to_slave, tvalid_to_master, tlast_to_master, frame_err, tdata_to_master},
              64'd0);
        _rst = 1'b1;
        check("ready_at_release", {63'd0, tready_to_slave}, 64'd0);
        repeat (2) @(negedge clk);
        check("ready_after_2_edges", {63'd0, tready_to_slave}, 64'd1);

        // a=10234, b=566 with latency checks.
        send_frame(32'd10234, 32'd566, 7, 8);
        check("calc_ready_low", {62'd0, tready_to_slave, tvalid_to_master}, 64'd0);
        @(negedge clk);
        check("no_valid_e1", {63'd0, tvalid_to_master}, 64'd0);
        @(negedge clk);
        check("first_beat_e2", {55'd0, tvalid_to_master, tdata_to_master}, {55'd0, 1'b1, 8'hBC});
        recv_frame(8, -1, 0, 64'h5862BC, prod, lasts);
        check("prod_10234x566", prod, 64'h5862BC);
        check("tlast_10234x566", {56'd0, lasts}, 64'h80);
        check("ready_after_tx", {63'd0, tready_to_slave}, 64'd1);

        // All-ones operands.
        send_frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 8);
        recv_frame(8, -1, 0, 64'hFFFF_FFFE_0000_0001, prod, lasts);
        check("prod_all_ones", prod, 64'hFFFF_FFFE_0000_0001);
        check("tlast_all_ones", {56'd0, lasts}, 64'h80);

        // Back-pressure on beat 2 for three cycles.
        send_frame(32'd10234, 32'd566, 7, 8);
        recv_frame(8, 2, 3, 64'h5862BC, prod, lasts);
        check("prod_stalled", prod, 64'h5862BC);
        check("tlast_stalled", {56'd0, lasts}, 64'h80);

        // Early tlast on beat 3: aborted frame, no response.
        send_frame(32'h1122_3344, 32'h5566_7788, 3, 4);
        check("frame_err_pulse", {63'd0, frame_err}, 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) check("frame_err_one_cycle", {63'd0, frame_err}, 64'd0);
            seen = seen | tvalid_to_master;
        end
        check("no_resp_after_abort", {62'd0, seen, tready_to_slave}, 64'd1);
        send_frame(32'd2, 32'd3, 7, 8);
        recv_frame(8, -1, 0, 64'h6, prod, lasts);
        check("prod_after_abort", prod, 64'h6);

        // Table vectors; junk operand beats with tlast are offered while not ready.
        foreach (vecs[i]) begin
            send_frame(vecs[i].a, vecs[i].b, 7, 8);
            tdata_to_slave  = 8'hAA;
            tvalid_to_slave = 1'b1;
            tlast_to_slave  = 1'b1;
            recv_frame(8, -1, 0, vecs[i].prod, prod, lasts);
            tvalid_to_slave = 1'b0;
            tlast_to_slave  = 1'b0;
            check($sformatf("prod_vec%0d", i), prod, vecs[i].prod);
            check($sformatf("tlast_vec%0d", i), {56'd0, lasts}, 64'h80);
        end

        // Asynchronous reset while beat 4 is presented.
        send_frame(32'd10234, 32'd566, 7, 8);
        recv_frame(4, -1, 0, 64'h5862BC, prod, lasts);
        check("beat4_presented", {55'd0, tvalid_to_master, tdata_to_master}, {55'd0, 1'b1, 8'h00});
        tready_to_master = 1'b0;
        _rst = 1'b0;
        #1;
        check("async_reset_outputs",
              {52'd0, tready_to_slave, tvalid_to_master, tlast_to_master, frame_err, tdata_to_master},
              64'd0);
        @(negedge clk);
        _rst = 1'b1;
        tready_to_master = 1'b1;
        check("ready_low_after_release", {63'd0, tready_to_slave}, 64'd0);
        repeat (2) @(negedge clk);
        check("ready_2_edges_after_reset", {63'd0, tready_to_slave}, 64'd1);
        send_frame(32'd7, 32'd6, 7, 8);
        recv_frame(8, -1, 0, 64'h2A, prod, lasts);
        check("prod_after_reset", prod, 64'h2A);
        check("tlast_after_reset", {56'd0, lasts}, 64'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
